// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity types and framing
// bit levels. The framing and parity constants are common to the TX side.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Per-frame framing options, captured when a start bit is detected.
    typedef struct packed {
        logic par_en;
        logic par_typ;
    } rx_cfg_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing and centre sampling for the UART receiver.
// edge_cnt counts oversampling ticks inside one bit. Three samples are taken
// around the bit centre; the majority vote is presented combinationally in
// the cycle holding the third sample, flagged by vote_valid.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      rx_s,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      vote,
    output logic                      vote_valid,
    output logic                      bit_end
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] last;
    logic                      s0;
    logic                      s1;

    assign half = prescale >> 1;
    assign last = prescale - PRESCALE_WIDTH'(1);

    // ">=" rather than "==" keeps the counter wrapping even for nonsense
    // prescale values, so the FSM can never stall waiting for a bit end.
    assign bit_end    = run && (edge_cnt >= last);
    assign vote_valid = run && (edge_cnt == half + PRESCALE_WIDTH'(1));
    assign vote       = majority3(s0, s1, rx_s);

    // Tick counter within a bit; parked at zero while the receiver is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (!run || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

    // Capture the first two of the three centre samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (run) begin
            if (edge_cnt == half - PRESCALE_WIDTH'(1)) begin
                s0 <= rx_s;
            end
            if (edge_cnt == half) begin
                s1 <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchroniser, framing FSM, deserialiser,
// parity/stop checks and registered one-cycle result pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for rx_s low
// ST_START  | qualifying the start bit; a high vote is a glitch -> idle
// ST_DATA   | shifting DATA_WIDTH bits in, LSB first
// ST_PARITY | sampling the parity bit and recording any mismatch
// ST_STOP   | stop bit vote decides the frame, then straight back to idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                      rx_meta;
    logic                      rx_s;
    logic [2:0]                state;
    logic [2:0]                state_nxt;
    rx_cfg_t                   cfg;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_mismatch;
    logic                      vote;
    logic                      vote_valid;
    logic                      bit_end;
    logic                      last_bit;
    logic                      frame_done;
    logic                      par_exp;
    logic                      stop_bad;
    logic                      par_bad;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk       (CLK),
        .rst       (RST),
        .run       (state != ST_IDLE),
        .rx_s      (rx_s),
        .prescale  (prescale_q),
        .vote      (vote),
        .vote_valid(vote_valid),
        .bit_end   (bit_end)
    );

    assign last_bit   = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
    // A stop bit normally ends at its vote; bit_end only matters when an
    // illegal prescale means the vote point is never reached.
    assign frame_done = (state == ST_STOP) && (vote_valid || bit_end);
    assign par_exp    = (^shift_reg) ^ (cfg.par_typ == PAR_ODD);
    assign stop_bad   = (vote != STOP_BIT);
    assign par_bad    = cfg.par_en & par_mismatch;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // Next-state logic for the framing FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_s == START_BIT) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (vote_valid && (vote != START_BIT)) begin
                    state_nxt = ST_IDLE;
                end else if (bit_end) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && last_bit) begin
                    state_nxt = cfg.par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (frame_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, per-frame configuration latch and deserialiser.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            cfg          <= '0;
            prescale_q   <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_mismatch <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_START) begin
                        cfg          <= '{par_en: PAR_EN, par_typ: PAR_TYP};
                        prescale_q   <= Prescale;
                        bit_cnt      <= '0;
                        par_mismatch <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (vote_valid) begin
                        shift_reg <= (shift_reg >> 1)
                                   | (DATA_WIDTH'(vote) << (DATA_WIDTH - 1));
                    end
                    if (bit_end) begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (vote_valid) begin
                        par_mismatch <= (vote != par_exp);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame result: one-cycle flags, and P_DATA updated only on a good frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (frame_done) begin
                framing_error <= stop_bad;
                parity_error  <= par_bad;
                if (!stop_bad && !par_bad) begin
                    data_valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule
